// File: rtl/ghost_move_scheduler_pkg.sv
// Shared types and default sizing for the ghost move scheduler and the ghost sprites it drives.
package ghost_sched_pkg;

    localparam int DEF_CNT_W      = 26;
    localparam int DEF_TIME_MAX   = 4000000;
    localparam int DEF_MIN_PERIOD = 500000;
    localparam int DEF_NUM_GHOSTS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_ISSUE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/ghost_move_scheduler_timer.sv
// Move-period counter with a score-clamped period that is reloaded only at terminal count.
// terminal_o is combinational off registered state; take_i restarts the period and latches the new length.
module ghost_period_timer #(
    parameter int TIME_MAX   = ghost_sched_pkg::DEF_TIME_MAX,
    parameter int MIN_PERIOD = ghost_sched_pkg::DEF_MIN_PERIOD,
    parameter int CNT_W      = ghost_sched_pkg::DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc_i,
    input  logic             take_i,
    input  logic [CNT_W-1:0] speed_offset_i,
    output logic             terminal_o,
    output logic [CNT_W-1:0] period_o
);

    localparam logic [CNT_W-1:0] PERIOD_MAX    = CNT_W'(TIME_MAX);
    localparam logic [CNT_W-1:0] PERIOD_MIN    = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] MAX_REDUCTION = CNT_W'(TIME_MAX - MIN_PERIOD);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] new_period;

    // Clamp before subtracting so a large offset can never wrap the period.
    assign new_period = (speed_offset_i >= MAX_REDUCTION) ? PERIOD_MIN
                                                          : PERIOD_MAX - speed_offset_i;

    assign terminal_o = (cnt_q == period_q - CNT_W'(1));
    assign period_o   = period_q;

    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        if (take_i) begin
            cnt_d    = '0;
            period_d = new_period;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            period_q <= PERIOD_MAX;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

endmodule

// File: rtl/ghost_move_scheduler.sv
// Global ghost move-tick scheduler: one period timer, staggered one-hot sweep over all ghost slots.
// Slot i ticks i+1 cycles after terminal count; enable only pauses counting, never an issuing sweep.
module ghost_move_scheduler #(
    parameter int NUM_GHOSTS = ghost_sched_pkg::DEF_NUM_GHOSTS,
    parameter int TIME_MAX   = ghost_sched_pkg::DEF_TIME_MAX,
    parameter int MIN_PERIOD = ghost_sched_pkg::DEF_MIN_PERIOD,
    parameter int CNT_W      = ghost_sched_pkg::DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [CNT_W-1:0]      speed_offset,
    input  logic [NUM_GHOSTS-1:0] ghost_active,
    output logic [NUM_GHOSTS-1:0] move_tick,
    output logic                  sweep_done,
    output logic [CNT_W-1:0]      cur_period
);

    import ghost_sched_pkg::*;

    localparam int             IDX_W    = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GHOSTS - 1);

    // A sweep must finish before the shortest possible period can expire.
    if (NUM_GHOSTS >= MIN_PERIOD) begin : g_cfg_err
        $error("ghost_move_scheduler: NUM_GHOSTS must be smaller than MIN_PERIOD");
    end
    if (MIN_PERIOD > TIME_MAX) begin : g_period_err
        $error("ghost_move_scheduler: MIN_PERIOD must not exceed TIME_MAX");
    end

    sched_state_t          state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [NUM_GHOSTS-1:0] move_tick_q;
    logic                  sweep_done_q;

    logic terminal;
    logic cnt_inc;
    logic cnt_take;

    // The counter keeps running through a sweep so the period stays exact.
    assign cnt_take = (state_q == ST_COUNT) && enable && terminal;
    assign cnt_inc  = ((state_q == ST_COUNT) && enable) || (state_q == ST_ISSUE);

    ghost_period_timer #(
        .TIME_MAX   (TIME_MAX),
        .MIN_PERIOD (MIN_PERIOD),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk            (clk),
        .reset_n        (reset_n),
        .inc_i          (cnt_inc),
        .take_i         (cnt_take),
        .speed_offset_i (speed_offset),
        .terminal_o     (terminal),
        .period_o       (cur_period)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            move_tick_q  <= '0;
            sweep_done_q <= 1'b0;
        end else begin
            move_tick_q  <= '0;
            sweep_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (!enable) begin
                        state_q <= ST_IDLE;
                    end else if (terminal) begin
                        idx_q   <= '0;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    move_tick_q[idx_q] <= ghost_active[idx_q];
                    idx_q              <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        idx_q        <= '0;
                        sweep_done_q <= 1'b1;
                        state_q      <= enable ? ST_COUNT : ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign move_tick  = move_tick_q;
    assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_ghost_move_scheduler.sv
// Directed bench for ghost_move_scheduler with a cycle-stamped scoreboard of expected tick sweeps.
module tb_ghost_move_scheduler;

    localparam int NG = 4;
    localparam int TM = 20;
    localparam int MP = 5;
    localparam int CW = 26;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [CW-1:0] speed_offset;
    logic [NG-1:0] ghost_active;
    logic [NG-1:0] move_tick;
    logic          sweep_done;
    logic [CW-1:0] cur_period;

    always #5 clk = ~clk;

    ghost_move_scheduler #(
        .NUM_GHOSTS (NG),
        .TIME_MAX   (TM),
        .MIN_PERIOD (MP),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .speed_offset (speed_offset),
        .ghost_active (ghost_active),
        .move_tick    (move_tick),
        .sweep_done   (sweep_done),
        .cur_period   (cur_period)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            c;
        logic [NG-1:0] tick;
        logic          done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Returns inside cycle n, 1 time unit after its rising edge.
    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Terminal count at edge t: slot i is issued in cycle t+1+i, done with the last slot.
    task automatic push_sweep(input int t, input logic [NG-1:0] mask);
        exp_t e;
        for (int i = 0; i < NG; i++) begin
            e.c    = t + 1 + i;
            e.tick = mask[i] ? NG'(1 << i) : '0;
            e.done = (i == NG - 1);
            exp_q.push_back(e);
        end
    endtask

    // Every monitored cycle is compared: scheduled sweep slots, otherwise all quiet.
    always @(negedge clk) begin
        logic [NG-1:0] et;
        logic          ed;
        if (mon_on) begin
            et = '0;
            ed = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
                et = exp_q[0].tick;
                ed = exp_q[0].done;
                void'(exp_q.pop_front());
            end
            chk("move_tick", 32'(move_tick), 32'(et));
            chk("sweep_done", 32'(sweep_done), 32'(ed));
        end
    end

    initial begin
        int t;
        int r;
        exp_t e;

        reset_n      = 1'b0;
        enable       = 1'b1;
        speed_offset = '0;
        ghost_active = 4'b1111;

        // Reset state
        wait_cyc(3);
        chk("rst_move_tick", 32'(move_tick), 32'd0);
        chk("rst_sweep_done", 32'(sweep_done), 32'd0);
        chk("rst_cur_period", 32'(cur_period), 32'd20);

        // 1: free-running sweeps every 20 cycles
        wait_cyc(4);
        reset_n = 1'b1;
        r       = 4;
        mon_on  = 1'b1;
        t       = r + 21;
        push_sweep(t, 4'b1111);
        push_sweep(t + 20, 4'b1111);
        push_sweep(t + 40, 4'b1111);
        wait_cyc(t + 5);
        chk("t1_cur_period", 32'(cur_period), 32'd20);
        t = t + 40;

        // 2: mid-period offset change applies from the next period
        wait_cyc(t + 10);
        speed_offset = CW'(12);
        t = t + 20;
        wait_cyc(t - 1);
        chk("t2_period_before", 32'(cur_period), 32'd20);
        push_sweep(t, 4'b1111);
        push_sweep(t + 8, 4'b1111);
        push_sweep(t + 16, 4'b1111);
        wait_cyc(t);
        chk("t2_period_after", 32'(cur_period), 32'd8);
        t = t + 16;

        // 3: clamp to MIN_PERIOD, and the clamp boundary either side
        wait_cyc(t + 2);
        speed_offset = CW'(30);
        t = t + 8;
        push_sweep(t, 4'b1111);
        push_sweep(t + 5, 4'b1111);
        push_sweep(t + 10, 4'b1111);
        wait_cyc(t);
        chk("t3_clamp_30", 32'(cur_period), 32'd5);
        t = t + 10;
        wait_cyc(t + 2);
        speed_offset = CW'(14);
        t = t + 5;
        push_sweep(t, 4'b1111);
        wait_cyc(t);
        chk("t3_offset_14", 32'(cur_period), 32'd6);
        wait_cyc(t + 2);
        speed_offset = CW'(15);
        t = t + 6;
        push_sweep(t, 4'b1111);
        wait_cyc(t);
        chk("t3_offset_15", 32'(cur_period), 32'd5);
        wait_cyc(t + 2);
        speed_offset = '0;
        t = t + 5;
        push_sweep(t, 4'b1111);
        wait_cyc(t);
        chk("t3_back_to_20", 32'(cur_period), 32'd20);

        // 4: partial activity; bit 1 raised only for its own slot
        wait_cyc(t + 6);
        ghost_active = 4'b0101;
        t = t + 20;
        push_sweep(t, 4'b0111);
        wait_cyc(t + 1);
        ghost_active = 4'b0111;
        wait_cyc(t + 2);
        ghost_active = 4'b0101;
        t = t + 20;
        push_sweep(t, 4'b0101);

        // 5: pause at cnt=7 for 50 cycles, then pause during a sweep
        wait_cyc(t + 7);
        enable = 1'b0;
        wait_cyc(t + 10);
        ghost_active = 4'b1111;
        wait_cyc(t + 30);
        chk("t5_paused_period", 32'(cur_period), 32'd20);
        wait_cyc(t + 57);
        enable = 1'b1;
        t = t + 71;
        push_sweep(t, 4'b1111);
        wait_cyc(t + 1);
        enable = 1'b0;
        wait_cyc(t + 34);
        enable = 1'b1;
        t = t + 51;
        push_sweep(t, 4'b1111);

        // 6: reset in the middle of a sweep
        wait_cyc(t + 5);
        speed_offset = CW'(12);
        t = t + 20;
        e.c    = t + 1;
        e.tick = 4'b0001;
        e.done = 1'b0;
        exp_q.push_back(e);
        wait_cyc(t + 1);
        chk("t6_period_latched", 32'(cur_period), 32'd8);
        wait_cyc(t + 2);
        chk("t6_slot1_before_rst", 32'(move_tick), 32'b0010);
        reset_n = 1'b0;
        #1;
        chk("t6_async_move_tick", 32'(move_tick), 32'd0);
        chk("t6_async_sweep_done", 32'(sweep_done), 32'd0);
        chk("t6_async_cur_period", 32'(cur_period), 32'd20);
        wait_cyc(t + 5);
        reset_n = 1'b1;
        r = t + 5;
        t = r + 21;
        push_sweep(t, 4'b1111);
        push_sweep(t + 8, 4'b1111);
        wait_cyc(r + 1);
        chk("t6_release_period", 32'(cur_period), 32'd20);
        wait_cyc(t);
        chk("t6_next_period", 32'(cur_period), 32'd8);
        wait_cyc(t + 14);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ghost_move_scheduler.md
Name: ghost_move_scheduler

Overview:
Central move-tick scheduler for all ghost sprites. It replaces the per-ghost timers and the ticks that are not derived from the clock domain. One clk-synchronous period timer, with a score-dependent period, issues one-cycle move enables to every active ghost in a staggered round-robin sweep. Ghost modules update position only on their move_tick bit. It sits between the score logic and the ghost instances in the top level.

Parameters:
NUM_GHOSTS, 4, number of ghost slots / width of tick vectors
TIME_MAX, 4000000, base move period in clk cycles at speed_offset = 0
MIN_PERIOD, 500000, floor on the move period, independent of score
CNT_W, 26, width of the period counter and speed_offset

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  game running; low pauses scheduling
speed_offset  in  CNT_W  score-dependent period reduction
ghost_active  in  NUM_GHOSTS  bit i high = ghost i spawned and alive
move_tick  out  NUM_GHOSTS  one-hot, one-cycle move enable per ghost
sweep_done  out  1  one-cycle pulse on the last slot of each sweep
cur_period  out  CNT_W  period currently in force (debug/HUD)

Behaviour:
- Reset: clk is the only clock; reset is asynchronous and active-low. Reset forces state=IDLE, cnt=0, period_reg=TIME_MAX, idx=0, move_tick=0, sweep_done=0, cur_period=TIME_MAX. All outputs are registered.
- Period calc (combinational):
  - new_period = MIN_PERIOD if speed_offset >= TIME_MAX-MIN_PERIOD, else TIME_MAX-speed_offset.
  - The compare is done before the subtraction, so there is never an underflow.
  - new_period is latched into period_reg only at a terminal count. A speed_offset change mid-period takes effect from the following period.
- FSM states: IDLE, COUNT, ISSUE.
  - IDLE:
    - cnt holds.
    - enable=1 -> COUNT on the next edge.
  - COUNT:
    - cnt increments each cycle.
    - enable=0 -> IDLE, cnt held (the pause resumes mid-period, no restart).
    - If cnt==period_reg-1 at an edge: cnt<=0, period_reg<=new_period, idx<=0, -> ISSUE.
  - ISSUE:
    - cnt keeps incrementing, so the period stays exact.
    - Each cycle: move_tick<=ghost_active[idx] in bit idx, others 0; idx++.
    - When idx==NUM_GHOSTS-1: sweep_done<=1 with that slot; next state is COUNT if enable=1, else IDLE.
    - enable falling during ISSUE does not abort the sweep. No ghost starves.
- Timing: if the terminal count is sampled at edge T:
  - move_tick[i] is high in cycle T+1+i.
  - sweep_done is high in cycle T+NUM_GHOSTS.
  - Sweep length is always NUM_GHOSTS cycles, even with inactive slots.
- ghost_active is sampled per slot, in the cycle the slot is issued.
- Period between consecutive move_tick[i] pulses = period_reg of that interval, exactly.
- Requirement: NUM_GHOSTS < MIN_PERIOD (elaboration-time assertion).
- Reset mid-ISSUE: move_tick drops to 0 asynchronously; no partial sweep resumes after release.

Decomposition:
- Shared package ghost_sched_pkg: FSM state enum, TIME_MAX/MIN_PERIOD defaults, CNT_W.
- Ghost modules import CNT_W from the package.
- One sub-module: ghost_period_timer, containing the counter, clamp calc, period_reg, and terminal flag. The FSM and tick issue logic stay in the top.

Test Plan (TIME_MAX=20, MIN_PERIOD=5, NUM_GHOSTS=4 unless stated):
1. Reset release; enable=1 from cycle 0; speed_offset=0; ghost_active=4'b1111. Required response:
   - move_tick = 0001, 0010, 0100, 1000 on consecutive cycles, repeating every 20 cycles.
   - sweep_done coincides with 1000.
   - cur_period=20.
2. speed_offset changed 0->12 mid-period. Required response:
   - The current interval stays 20.
   - Next intervals are 8.
   - cur_period updates to 8 at the terminal count.
3. speed_offset=30 (> TIME_MAX). Required response: period clamps to 5, with no wrap to a huge value; ticks every 5 cycles.
4. ghost_active=4'b0101. Required response:
   - Only bit 0 (sweep cycle 1) and bit 2 (cycle 3) pulse.
   - sweep_done is still on cycle 4.
   - Toggling bit 1 high at slot-1 cycle yields a tick for bit 1.
5. enable=0 at cnt=7 for 50 cycles, then 1. Required response:
   - No ticks during the pause.
   - The first sweep follows 13 cycles after resume.
   - enable=0 during ISSUE: all 4 slots still issue, then IDLE.
6. reset_n low during ISSUE slot 1. Required response:
   - move_tick=0 within the same cycle, asynchronously.
   - After release: cnt=0, cur_period=20, no ticks until a full period has elapsed after enable.
